// File: rtl/pc_sequencer.sv
// Program-counter register and next-PC selector around an external PC+4 adder.
// Issues fetches over valid/ready, buffers one redirect under back-pressure, traps misaligned targets.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [31:0] PCAddResult,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic        FetchReady,
   output logic [31:0] PCResult,
   output logic        FetchValid,
   output logic        AddrError,
   output logic [31:0] BadAddr,
   output logic [31:0] FetchCount
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      EXC   = 2'd2
   } state_t;

   state_t      state;

   logic        pend_vld_p0;
   logic [31:0] pend_tgt_p0;

   logic        xfer;
   logic        redir_vld;
   logic [31:0] redir_tgt;
   logic        src_redir;
   logic [31:0] next_pc;
   logic        trap;

   function automatic logic misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

   assign FetchValid = (state == FETCH);
   assign xfer       = FetchValid && FetchReady;

   // Jump outranks branch; a live redirect outranks a buffered one, which outranks PC+4.
   always_comb begin
      redir_vld = Jump || BranchTaken;
      redir_tgt = Jump ? JumpTarget : BranchTarget;
      src_redir = 1'b0;
      next_pc   = PCAddResult;
      if (redir_vld) begin
         src_redir = 1'b1;
         next_pc   = redir_tgt;
      end else if (pend_vld_p0) begin
         src_redir = 1'b1;
         next_pc   = pend_tgt_p0;
      end
      trap = src_redir && misaligned(next_pc);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state       <= BOOT;
         PCResult    <= RESET_PC;
         AddrError   <= 1'b0;
         BadAddr     <= 32'h0;
         FetchCount  <= 32'h0;
         pend_vld_p0 <= 1'b0;
         pend_tgt_p0 <= 32'h0;
      end else begin
         AddrError <= 1'b0;
         case (state)
            BOOT: state <= FETCH;
            EXC:  state <= FETCH;
            FETCH: begin
               if (xfer) begin
                  FetchCount  <= FetchCount + 32'd1;
                  pend_vld_p0 <= 1'b0;
                  pend_tgt_p0 <= 32'h0;
                  if (trap) begin
                     PCResult  <= EXC_VECTOR;
                     BadAddr   <= next_pc;
                     AddrError <= 1'b1;
                     state     <= EXC;
                  end else begin
                     PCResult  <= next_pc;
                  end
               end else if (redir_vld) begin
                  // Newest redirect wins; misaligned values are kept and trap on consumption.
                  pend_vld_p0 <= 1'b1;
                  pend_tgt_p0 <= redir_tgt;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: vector table plus hand-written wrap and reset sequences.
module tb_pc_sequencer;

   logic        Clk;
   logic        Reset;
   logic [31:0] PCAddResult;
   logic        BranchTaken;
   logic [31:0] BranchTarget;
   logic        Jump;
   logic [31:0] JumpTarget;
   logic        FetchReady;
   logic [31:0] PCResult;
   logic        FetchValid;
   logic        AddrError;
   logic [31:0] BadAddr;
   logic [31:0] FetchCount;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        r;
      logic        j;
      logic [31:0] jt;
      logic        b;
      logic [31:0] bt;
      logic [31:0] pc;
      logic        vld;
      logic        err;
      logic [31:0] bad;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[$];

   pc_sequencer #(
      .RESET_PC   (32'h0000_0000),
      .EXC_VECTOR (32'h8000_0180)
   ) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .PCAddResult  (PCAddResult),
      .BranchTaken  (BranchTaken),
      .BranchTarget (BranchTarget),
      .Jump         (Jump),
      .JumpTarget   (JumpTarget),
      .FetchReady   (FetchReady),
      .PCResult     (PCResult),
      .FetchValid   (FetchValid),
      .AddrError    (AddrError),
      .BadAddr      (BadAddr),
      .FetchCount   (FetchCount)
   );

   // The external PC adder.
   assign PCAddResult = PCResult + 32'd4;

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required finish earlier");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [31:0] pc, input logic vld,
                          input logic err, input logic [31:0] bad, input logic [31:0] cnt);
      chk({tag, ".pc"},  PCResult,           pc);
      chk({tag, ".vld"}, {31'h0, FetchValid}, {31'h0, vld});
      chk({tag, ".err"}, {31'h0, AddrError},  {31'h0, err});
      chk({tag, ".bad"}, BadAddr,            bad);
      chk({tag, ".cnt"}, FetchCount,         cnt);
   endtask

   function automatic vec_t v(logic r, logic j, logic [31:0] jt, logic b, logic [31:0] bt,
                              logic [31:0] pc, logic vld, logic err, logic [31:0] bad,
                              logic [31:0] cnt);
      vec_t x;
      x.r = r; x.j = j; x.jt = jt; x.b = b; x.bt = bt;
      x.pc = pc; x.vld = vld; x.err = err; x.bad = bad; x.cnt = cnt;
      return x;
   endfunction

   task automatic drive(input logic r, input logic j, input logic [31:0] jt,
                        input logic b, input logic [31:0] bt);
      FetchReady   = r;
      Jump         = j;
      JumpTarget   = jt;
      BranchTaken  = b;
      BranchTarget = bt;
   endtask

   initial begin
      //          r  j  jt          b  bt          pc            vld err bad         cnt
      vecs.push_back(v(1, 0, 32'h0,     0, 32'h0,     32'h0,        1, 0, 32'h0,   0));
      vecs.push_back(v(1, 0, 32'h0,     0, 32'h0,     32'h4,        1, 0, 32'h0,   1));
      vecs.push_back(v(1, 0, 32'h0,     0, 32'h0,     32'h8,        1, 0, 32'h0,   2));
      vecs.push_back(v(1, 0, 32'h0,     0, 32'h0,     32'hC,        1, 0, 32'h0,   3));
      vecs.push_back(v(1, 0, 32'h0,     0, 32'h0,     32'h10,       1, 0, 32'h0,   4));
      vecs.push_back(v(0, 0, 32'h0,     0, 32'h0,     32'h10,       1, 0, 32'h0,   4));
      vecs.push_back(v(0, 0, 32'h0,     0, 32'h0,     32'h10,       1, 0, 32'h0,   4));
      vecs.push_back(v(0, 0, 32'h0,     0, 32'h0,     32'h10,       1, 0, 32'h0,   4));
      vecs.push_back(v(1, 0, 32'h0,     0, 32'h0,     32'h14,       1, 0, 32'h0,   5));
      vecs.push_back(v(1, 0, 32'h0,     0, 32'h0,     32'h18,       1, 0, 32'h0,   6));
      vecs.push_back(v(1, 0, 32'h0,     0, 32'h0,     32'h1C,       1, 0, 32'h0,   7));
      vecs.push_back(v(1, 0, 32'h0,     0, 32'h0,     32'h20,       1, 0, 32'h0,   8));
      vecs.push_back(v(0, 0, 32'h0,     1, 32'h100,   32'h20,       1, 0, 32'h0,   8));
      vecs.push_back(v(0, 0, 32'h0,     0, 32'h0,     32'h20,       1, 0, 32'h0,   8));
      vecs.push_back(v(1, 0, 32'h0,     0, 32'h0,     32'h100,      1, 0, 32'h0,   9));
      vecs.push_back(v(1, 0, 32'h0,     0, 32'h0,     32'h104,      1, 0, 32'h0,  10));
      vecs.push_back(v(1, 1, 32'h400,   1, 32'h200,   32'h400,      1, 0, 32'h0,  11));
      vecs.push_back(v(0, 0, 32'h0,     1, 32'h300,   32'h400,      1, 0, 32'h0,  11));
      vecs.push_back(v(0, 1, 32'h500,   0, 32'h0,     32'h400,      1, 0, 32'h0,  11));
      vecs.push_back(v(1, 0, 32'h0,     0, 32'h0,     32'h500,      1, 0, 32'h0,  12));
      vecs.push_back(v(0, 0, 32'h0,     1, 32'h600,   32'h500,      1, 0, 32'h0,  12));
      vecs.push_back(v(1, 0, 32'h0,     1, 32'h700,   32'h700,      1, 0, 32'h0,  13));
      vecs.push_back(v(1, 1, 32'h402,   0, 32'h0,     32'h8000_0180, 0, 1, 32'h402, 14));
      vecs.push_back(v(1, 1, 32'h900,   0, 32'h0,     32'h8000_0180, 1, 0, 32'h402, 14));
      vecs.push_back(v(1, 0, 32'h0,     0, 32'h0,     32'h8000_0184, 1, 0, 32'h402, 15));
      vecs.push_back(v(0, 0, 32'h0,     1, 32'h801,   32'h8000_0184, 1, 0, 32'h402, 15));
      vecs.push_back(v(1, 0, 32'h0,     0, 32'h0,     32'h8000_0180, 0, 1, 32'h801, 16));
      vecs.push_back(v(1, 0, 32'h0,     0, 32'h0,     32'h8000_0180, 1, 0, 32'h801, 16));
      vecs.push_back(v(1, 0, 32'h0,     0, 32'h0,     32'h8000_0184, 1, 0, 32'h801, 17));

      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      Reset = 1'b1;
      #1 Reset = 1'b0;
      #2;
      chk_all("reset", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

      @(negedge Clk);
      Reset = 1'b1;
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      #1;
      chk_all("boot", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].r, vecs[i].j, vecs[i].jt, vecs[i].b, vecs[i].bt);
         @(posedge Clk);
         #1;
         chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].vld, vecs[i].err,
                 vecs[i].bad, vecs[i].cnt);
      end

      // Counter wrap: preload near the top, then one accepted fetch.
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      #1 force dut.FetchCount = 32'hFFFF_FFFF;
      #1 release dut.FetchCount;
      #1;
      chk("wrap.pre", FetchCount, 32'hFFFF_FFFF);
      FetchReady = 1'b1;
      @(posedge Clk);
      #1;
      chk_all("wrap", 32'h8000_0188, 1'b1, 1'b0, 32'h801, 32'h0);

      // Reset in the middle of a stalled fetch with a redirect buffered.
      drive(1'b0, 1'b1, 32'h1000, 1'b0, 32'h0);
      @(posedge Clk);
      #2;
      chk_all("stall", 32'h8000_0188, 1'b1, 1'b0, 32'h801, 32'h0);
      Reset = 1'b0;
      #1;
      chk_all("midrst", 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge Clk);
      Reset = 1'b1;
      @(posedge Clk);
      #1;
      chk_all("reboot", 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
      @(posedge Clk);
      #1;
      chk_all("refetch", 32'h4, 1'b1, 1'b0, 32'h0, 32'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
